wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter XLEN, default 32, data and register width.
REQ-002 Parameter CNT_W, default 32, width of the retire counter.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port MEM_WB_Data_in, input, XLEN, load data registered at MEM/WB.
REQ-006 Port MEM_WB_ALUout, input, XLEN, ALU result registered at MEM/WB.
REQ-007 Port MEM_WB_RD, input, 5, destination register index.
REQ-008 Port MEM_WB_RegWrite, input, 1, write-back request.
REQ-009 Port MEM_WB_WDSel, input, 3, write-data select.
REQ-010 Port ID_RS1, input, 5, read port 1 index.
REQ-011 Port ID_RS2, input, 5, read port 2 index.
REQ-012 Port RD1, output, XLEN, read port 1 data.
REQ-013 Port RD2, output, XLEN, read port 2 data.
REQ-014 Port WB_Data, output, XLEN, selected write-back data (combinational).
REQ-015 Port WB_we, output, 1, effective write enable this cycle (combinational).
REQ-016 Port WB_err, output, 1, sticky flag for an illegal WDSel on a requested write.
REQ-017 Port retire_cnt, output, CNT_W, count of committed register writes.

Function
REQ-018 WDSel decode: 3'b000 selects MEM_WB_ALUout; 3'b001 selects MEM_WB_Data_in; 3'b010 selects MEM_WB_ALUout (PC-relative and immediate results already formed by the ALU); 3'b011 to 3'b111 are illegal.
REQ-019 WB_Data shall be the decoded source; for illegal codes it shall be 0.
REQ-020 WB_we shall be MEM_WB_RegWrite AND (MEM_WB_RD != 0) AND legal WDSel AND NOT rst.
REQ-021 Register array: 32 entries of XLEN bits; entry 0 never written and always reads 0.
REQ-022 When WB_we is high, entry MEM_WB_RD takes WB_Data at the rising edge (one-cycle write latency).
REQ-023 Reads are combinational: RDn equals entry[ID_RSn].
REQ-024 Write-through bypass: if WB_we is high and ID_RSn == MEM_WB_RD, RDn shall equal WB_Data in the same cycle.
REQ-025 ID_RSn == 0 yields RDn = 0 regardless of any write or bypass.
REQ-026 Both read ports may address the same register, or the write target, in the same cycle; each resolves independently per REQ-023 to REQ-025.
REQ-027 WB_err shall set at the edge following any cycle with MEM_WB_RegWrite = 1 and illegal WDSel, including when RD = 0; it holds until reset; no register is written in that cycle.
REQ-028 retire_cnt shall increment by 1 at each edge where WB_we was high, and wrap from 2^CNT_W - 1 to 0.
REQ-029 With MEM_WB_RegWrite = 0, all inputs other than read indices are don't-care; no state shall change except under reset.

Reset
REQ-030 With rst high at a rising edge, all 32 entries, WB_err and retire_cnt shall clear to 0.
REQ-031 A write requested in a cycle with rst high shall be discarded; reset takes priority.
REQ-032 During rst high, RD1 and RD2 shall reflect the array contents without bypass; they read 0 from the edge after reset is first sampled.

Verification
REQ-033 Reset, then RegWrite=1, RD=5, WDSel=000, ALUout=0x1234 -> after the edge, ID_RS1=5 gives RD1=0x1234 and retire_cnt=1.
REQ-034 RegWrite=1, RD=7, WDSel=001, Data_in=0xDEADBEEF, ID_RS2=7 in the same cycle -> RD2=0xDEADBEEF combinationally (bypass); after the edge the array holds it.
REQ-035 RegWrite=1, RD=0, WDSel=000, ALUout=0xFFFFFFFF -> WB_we=0, RD1 with ID_RS1=0 stays 0, retire_cnt unchanged.
REQ-036 RegWrite=1, RD=3, WDSel=101 -> WB_we=0, x3 unchanged, WB_err=1 after the edge and held across later legal writes until rst.
REQ-037 Preload retire_cnt to 0xFFFFFFFF through 2^32-1 writes (or force it) -> one more legal write gives retire_cnt=0.
REQ-038 rst=1 together with RegWrite=1, RD=9, ALUout=0x55 -> x9=0, retire_cnt=0, WB_err=0 after the edge.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage register file: 32 x XLEN array with write-through bypass,
// write-data select decode, sticky illegal-select flag and a retire counter.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  MEM_WB_Data_in,
  input  logic [XLEN-1:0]  MEM_WB_ALUout,
  input  logic [4:0]       MEM_WB_RD,
  input  logic             MEM_WB_RegWrite,
  input  logic [2:0]       MEM_WB_WDSel,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  output logic [XLEN-1:0]  RD1,
  output logic [XLEN-1:0]  RD2,
  output logic [XLEN-1:0]  WB_Data,
  output logic             WB_we,
  output logic             WB_err,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [XLEN-1:0]  r_regs [32];
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             w_legal;
  logic             w_byp1;
  logic             w_byp2;

  assign w_legal = (MEM_WB_WDSel <= 3'd2);

  always_comb begin
    WB_Data = '0;
    case (MEM_WB_WDSel)
      3'b000:  WB_Data = MEM_WB_ALUout;
      3'b001:  WB_Data = MEM_WB_Data_in;
      3'b010:  WB_Data = MEM_WB_ALUout;
      default: WB_Data = '0;
    endcase
  end

  // WB_we already excludes reset, so bypass is naturally suppressed during rst.
  assign WB_we  = MEM_WB_RegWrite && (MEM_WB_RD != 5'd0) && w_legal && !rst;
  assign w_byp1 = WB_we && (ID_RS1 == MEM_WB_RD);
  assign w_byp2 = WB_we && (ID_RS2 == MEM_WB_RD);

  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (ID_RS1 != 5'd0) RD1 = w_byp1 ? WB_Data : r_regs[ID_RS1];
    if (ID_RS2 != 5'd0) RD2 = w_byp2 ? WB_Data : r_regs[ID_RS2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (WB_we) begin
        r_regs[MEM_WB_RD] <= WB_Data;
        r_cnt             <= r_cnt + 1'b1;
      end
      if (MEM_WB_RegWrite && !w_legal) r_err <= 1'b1;
    end
  end

  assign WB_err     = r_err;
  assign retire_cnt = r_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; CNT_W is reduced to 8 so counter wrap is reachable.
module tb_wb_regfile;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [XLEN-1:0]  MEM_WB_Data_in;
  logic [XLEN-1:0]  MEM_WB_ALUout;
  logic [4:0]       MEM_WB_RD;
  logic             MEM_WB_RegWrite;
  logic [2:0]       MEM_WB_WDSel;
  logic [4:0]       ID_RS1;
  logic [4:0]       ID_RS2;
  logic [XLEN-1:0]  RD1;
  logic [XLEN-1:0]  RD2;
  logic [XLEN-1:0]  WB_Data;
  logic             WB_we;
  logic             WB_err;
  logic [CNT_W-1:0] retire_cnt;

  int checks   = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_cnt;

  wb_regfile #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .MEM_WB_Data_in(MEM_WB_Data_in), .MEM_WB_ALUout(MEM_WB_ALUout),
    .MEM_WB_RD(MEM_WB_RD), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .MEM_WB_WDSel(MEM_WB_WDSel), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .RD1(RD1), .RD2(RD2), .WB_Data(WB_Data), .WB_we(WB_we),
    .WB_err(WB_err), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [2:0] sel,
                       input logic [31:0] alu, input logic [31:0] din);
    MEM_WB_RegWrite = we;
    MEM_WB_RD       = rd;
    MEM_WB_WDSel    = sel;
    MEM_WB_ALUout   = alu;
    MEM_WB_Data_in  = din;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ID_RS1 = 5'd9;
    ID_RS2 = 5'd5;
    drive(1'b1, 5'd9, 3'b000, 32'h55, 32'h0);
    checks++;
    if (WB_we !== 1'b0) begin
      failures++; $display("FAIL reset_we got=%b exp=0", WB_we);
    end
    tick();
    tick();
    checks++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
      failures++; $display("FAIL reset_reads got=%h/%h exp=0/0", RD1, RD2);
    end
    checks++;
    if (retire_cnt !== 8'h0 || WB_err !== 1'b0) begin
      failures++; $display("FAIL reset_state cnt=%h err=%b exp=0/0", retire_cnt, WB_err);
    end
    rst = 1'b0;
    drive(1'b0, 5'd0, 3'b000, 32'h0, 32'h0);
    exp_cnt = '0;
  endtask

  task automatic test_alu_write();
    drive(1'b1, 5'd5, 3'b000, 32'h1234, 32'hAAAA_0000);
    checks++;
    if (WB_we !== 1'b1 || WB_Data !== 32'h1234) begin
      failures++; $display("FAIL alu_comb we=%b data=%h exp=1/00001234", WB_we, WB_Data);
    end
    tick();
    exp_cnt++;
    drive(1'b0, 5'd0, 3'b000, 32'h0, 32'h0);
    ID_RS1 = 5'd5;
    #1;
    checks++;
    if (RD1 !== 32'h1234 || retire_cnt !== exp_cnt) begin
      failures++; $display("FAIL alu_write rd1=%h cnt=%h exp=00001234/%h", RD1, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_bypass();
    ID_RS1 = 5'd5;
    ID_RS2 = 5'd7;
    drive(1'b1, 5'd7, 3'b001, 32'h0, 32'hDEADBEEF);
    checks++;
    if (RD2 !== 32'hDEADBEEF || RD1 !== 32'h1234) begin
      failures++; $display("FAIL bypass rd2=%h rd1=%h exp=deadbeef/00001234", RD2, RD1);
    end
    tick();
    exp_cnt++;
    drive(1'b0, 5'd0, 3'b000, 32'h0, 32'h0);
    checks++;
    if (RD2 !== 32'hDEADBEEF || retire_cnt !== exp_cnt) begin
      failures++; $display("FAIL bypass_stored rd2=%h cnt=%h exp=deadbeef/%h", RD2, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_same_index();
    ID_RS1 = 5'd7;
    ID_RS2 = 5'd7;
    drive(1'b1, 5'd7, 3'b010, 32'h0000A5A5, 32'h1111_1111);
    checks++;
    if (RD1 !== 32'hA5A5 || RD2 !== 32'hA5A5 || WB_Data !== 32'hA5A5) begin
      failures++; $display("FAIL same_index rd1=%h rd2=%h wbd=%h exp=a5a5", RD1, RD2, WB_Data);
    end
    ID_RS2 = 5'd0;
    #1;
    checks++;
    if (RD2 !== 32'h0 || RD1 !== 32'hA5A5) begin
      failures++; $display("FAIL rs_zero_during_write rd2=%h rd1=%h exp=0/a5a5", RD2, RD1);
    end
    tick();
    exp_cnt++;
    drive(1'b0, 5'd0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic test_rd_zero();
    ID_RS1 = 5'd0;
    drive(1'b1, 5'd0, 3'b000, 32'hFFFFFFFF, 32'h0);
    checks++;
    if (WB_we !== 1'b0 || RD1 !== 32'h0) begin
      failures++; $display("FAIL rd_zero_comb we=%b rd1=%h exp=0/0", WB_we, RD1);
    end
    tick();
    drive(1'b0, 5'd0, 3'b000, 32'h0, 32'h0);
    checks++;
    if (RD1 !== 32'h0 || retire_cnt !== exp_cnt) begin
      failures++; $display("FAIL rd_zero rd1=%h cnt=%h exp=0/%h", RD1, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 5'd3, 3'b000, 32'h33, 32'h0);
    tick();
    exp_cnt++;
    ID_RS1 = 5'd3;
    drive(1'b1, 5'd3, 3'b101, 32'h99, 32'h98);
    checks++;
    if (WB_we !== 1'b0 || WB_Data !== 32'h0 || RD1 !== 32'h33) begin
      failures++; $display("FAIL illegal_comb we=%b wbd=%h rd1=%h exp=0/0/33", WB_we, WB_Data, RD1);
    end
    tick();
    drive(1'b0, 5'd0, 3'b000, 32'h0, 32'h0);
    checks++;
    if (WB_err !== 1'b1 || RD1 !== 32'h33 || retire_cnt !== exp_cnt) begin
      failures++; $display("FAIL illegal err=%b rd1=%h cnt=%h exp=1/33/%h", WB_err, RD1, retire_cnt, exp_cnt);
    end
    drive(1'b1, 5'd4, 3'b000, 32'h44, 32'h0);
    tick();
    exp_cnt++;
    drive(1'b1, 5'd9, 3'b001, 32'h0, 32'h77);
    tick();
    exp_cnt++;
    drive(1'b0, 5'd0, 3'b000, 32'h0, 32'h0);
    checks++;
    if (WB_err !== 1'b1 || retire_cnt !== exp_cnt) begin
      failures++; $display("FAIL err_sticky err=%b cnt=%h exp=1/%h", WB_err, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_priority();
    ID_RS1 = 5'd9;
    ID_RS2 = 5'd5;
    rst = 1'b1;
    drive(1'b1, 5'd9, 3'b000, 32'h55, 32'h0);
    checks++;
    if (WB_we !== 1'b0 || RD1 !== 32'h77 || RD2 !== 32'h1234) begin
      failures++; $display("FAIL rst_no_bypass we=%b rd1=%h rd2=%h exp=0/77/1234", WB_we, RD1, RD2);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 3'b000, 32'h0, 32'h0);
    exp_cnt = '0;
    checks++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0 || retire_cnt !== 8'h0 || WB_err !== 1'b0) begin
      failures++; $display("FAIL rst_priority rd1=%h rd2=%h cnt=%h err=%b exp=0/0/0/0", RD1, RD2, retire_cnt, WB_err);
    end
  endtask

  task automatic test_err_rd0();
    drive(1'b0, 5'd6, 3'b111, 32'h12, 32'h34);
    tick();
    checks++;
    if (WB_err !== 1'b0 || retire_cnt !== exp_cnt) begin
      failures++; $display("FAIL idle_dontcare err=%b cnt=%h exp=0/%h", WB_err, retire_cnt, exp_cnt);
    end
    drive(1'b1, 5'd0, 3'b011, 32'h12, 32'h34);
    tick();
    drive(1'b0, 5'd0, 3'b000, 32'h0, 32'h0);
    checks++;
    if (WB_err !== 1'b1) begin
      failures++; $display("FAIL err_rd0 got=%b exp=1", WB_err);
    end
  endtask

  task automatic test_wrap();
    int guard = 0;
    while (exp_cnt != 8'hFF && guard < 400) begin
      drive(1'b1, 5'(1 + (guard % 31)), 3'b000, 32'(guard), 32'h0);
      tick();
      exp_cnt++;
      guard++;
    end
    drive(1'b0, 5'd0, 3'b000, 32'h0, 32'h0);
    checks++;
    if (retire_cnt !== 8'hFF) begin
      failures++; $display("FAIL wrap_pre got=%h exp=ff", retire_cnt);
    end
    drive(1'b1, 5'd2, 3'b001, 32'h0, 32'hCAFE);
    tick();
    drive(1'b0, 5'd0, 3'b000, 32'h0, 32'h0);
    ID_RS1 = 5'd2;
    #1;
    checks++;
    if (retire_cnt !== 8'h00 || RD1 !== 32'hCAFE) begin
      failures++; $display("FAIL wrap got=%h rd1=%h exp=00/cafe", retire_cnt, RD1);
    end
  endtask

  initial begin
    rst = 1'b1;
    ID_RS1 = 5'd0;
    ID_RS2 = 5'd0;
    MEM_WB_RegWrite = 1'b0;
    MEM_WB_RD = 5'd0;
    MEM_WB_WDSel = 3'b000;
    MEM_WB_ALUout = '0;
    MEM_WB_Data_in = '0;
    exp_cnt = '0;
    test_reset();
    test_alu_write();
    test_bypass();
    test_same_index();
    test_rd_zero();
    test_illegal();
    test_reset_priority();
    test_err_rd0();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
